// File: rtl/e_mdu_pkg.sv
// Shared opcode and state encodings for the E-stage multiply/divide unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div into shadow regs, committed to HI/LO
// on the last busy cycle; single-cycle mthi/mtlo; combinational mfhi/mflo read port.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

  mdu_op_e        op;
  mdu_state_e     state;
  logic [CW-1:0]  cnt, cnt_n;
  logic [31:0]    hi_t, lo_t, hit_n, lot_n, hi_n, lo_n;
  logic           wr_t, wrt_n;

  logic [63:0]        prod_s, prod_u;
  logic [31:0]        dvsr, uq, ur;
  logic signed [32:0] sq, sr;

  assign op    = mdu_op_e'(MDUOp);
  assign state = (cnt == '0) ? ST_IDLE : ST_RUN;
  assign Busy  = (state == ST_RUN);

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced non-zero so the divider never sees 0; the zero case suppresses the commit.
  // The 33-bit signed form keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
  assign dvsr = (B == '0) ? 32'd1 : B;
  assign sq   = $signed({A[31], A}) / $signed({dvsr[31], dvsr});
  assign sr   = $signed({A[31], A}) % $signed({dvsr[31], dvsr});
  assign uq   = A / dvsr;
  assign ur   = A % dvsr;

  always_comb begin
    cnt_n = cnt;
    hi_n  = HI;
    lo_n  = LO;
    hit_n = hi_t;
    lot_n = lo_t;
    wrt_n = wr_t;
    case (state)
      ST_IDLE: begin
        if (!Req) begin
          if (Start && (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU})) begin
            case (op)
              MDU_MULT:  begin {hit_n, lot_n} = prod_s; cnt_n = MULT_LD; wrt_n = 1'b1; end
              MDU_MULTU: begin {hit_n, lot_n} = prod_u; cnt_n = MULT_LD; wrt_n = 1'b1; end
              MDU_DIV:   begin hit_n = sr[31:0]; lot_n = sq[31:0]; cnt_n = DIV_LD; wrt_n = (B != '0); end
              MDU_DIVU:  begin hit_n = ur; lot_n = uq; cnt_n = DIV_LD; wrt_n = (B != '0); end
              default: ;
            endcase
          end else if (op == MDU_MTHI) begin
            hi_n = A;
          end else if (op == MDU_MTLO) begin
            lo_n = A;
          end
        end
      end
      ST_RUN: begin
        cnt_n = cnt - 1'b1;
        if ((cnt == CW'(1)) && wr_t) begin
          hi_n = hi_t;
          lo_n = lo_t;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      HI   <= '0;
      LO   <= '0;
      hi_t <= '0;
      lo_t <= '0;
      wr_t <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      HI   <= hi_n;
      LO   <= lo_n;
      hi_t <= hit_n;
      lo_t <= lot_n;
      wr_t <= wrt_n;
    end
  end

  always_comb begin
    Out = '0;
    if (op == MDU_MFHI)      Out = HI;
    else if (op == MDU_MFLO) Out = LO;
  end

endmodule
